id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the integer ALU (arithmatic).
- Captures decoded operands and control from decode and applies EX/MEM and MEM/WB operand forwarding.
- Detects load-use hazards and inserts bubbles.
- Presents op1, op2, funct3, funct7, IMM_Type_flag and immediate to the ALU.
- Valid/ready handshake on both sides, plus a flush input for branch redirect.

---
 rtl/id_ex_stage_if.sv | 58 +++++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Bus between decode, the ID/EX register and the ALU, including the forwarding
// sources. The stage uses the slave modport; the driving environment uses master.
interface id_ex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IMM_W = 12,
    parameter int unsigned CNT_W = 16
);
    logic             flush;
    logic             id_valid;
    logic             id_ready;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic [4:0]       id_rd_addr;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [2:0]       id_funct3;
    logic [6:0]       id_funct7;
    logic [IMM_W-1:0] id_imm;
    logic             id_imm_type;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             exmem_reg_write;
    logic [4:0]       exmem_rd;
    logic [XLEN-1:0]  exmem_result;
    logic             memwb_reg_write;
    logic [4:0]       memwb_rd;
    logic [XLEN-1:0]  memwb_result;
    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             IMM_Type_flag;
    logic [IMM_W-1:0] immediate;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output flush, id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
               id_rs2_data, id_funct3, id_funct7, id_imm, id_imm_type, id_reg_write,
               id_mem_read, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
               memwb_rd, memwb_result, ex_ready,
        input  id_ready, ex_valid, op1, op2, funct3, funct7, IMM_Type_flag, immediate,
               ex_rd, ex_reg_write, ex_mem_read, bubble_cnt
    );

    modport slave (
        input  flush, id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
               id_rs2_data, id_funct3, id_funct7, id_imm, id_imm_type, id_reg_write,
               id_mem_read, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
               memwb_rd, memwb_result, ex_ready,
        output id_ready, ex_valid, op1, op2, funct3, funct7, IMM_Type_flag, immediate,
               ex_rd, ex_reg_write, ex_mem_read, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards its operands
// from EX/MEM and MEM/WB, and stalls decode with a bubble on a load-use hazard.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IMM_W = 12,
    parameter int unsigned CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    id_ex_stage_if.slave  bus_io
);
    logic             ex_valid_q, ex_valid_d;
    logic [4:0]       rs1_addr_q, rs1_addr_d;
    logic [4:0]       rs2_addr_q, rs2_addr_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [6:0]       funct7_q, funct7_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             imm_type_q, imm_type_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic             exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;
    logic [XLEN-1:0]  op1_fwd, op2_fwd;
    logic             slot_free, load_use;

    // x0 is never forwarded; EX/MEM is younger so it wins over MEM/WB.
    assign exmem_hit1 = bus_io.exmem_reg_write && (bus_io.exmem_rd != 5'd0) &&
                        (bus_io.exmem_rd == rs1_addr_q);
    assign exmem_hit2 = bus_io.exmem_reg_write && (bus_io.exmem_rd != 5'd0) &&
                        (bus_io.exmem_rd == rs2_addr_q);
    assign memwb_hit1 = bus_io.memwb_reg_write && (bus_io.memwb_rd != 5'd0) &&
                        (bus_io.memwb_rd == rs1_addr_q);
    assign memwb_hit2 = bus_io.memwb_reg_write && (bus_io.memwb_rd != 5'd0) &&
                        (bus_io.memwb_rd == rs2_addr_q);

    assign op1_fwd = exmem_hit1 ? bus_io.exmem_result :
                     memwb_hit1 ? bus_io.memwb_result : rs1_data_q;
    assign op2_fwd = exmem_hit2 ? bus_io.exmem_result :
                     memwb_hit2 ? bus_io.memwb_result : rs2_data_q;

    assign slot_free = !ex_valid_q || bus_io.ex_ready;
    assign load_use  = ex_valid_q && mem_read_q && (rd_q != 5'd0) && bus_io.id_valid &&
                       ((rd_q == bus_io.id_rs1_addr) ||
                        (!bus_io.id_imm_type && (rd_q == bus_io.id_rs2_addr)));

    assign bus_io.id_ready = !bus_io.flush && !load_use && slot_free;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        rd_d         = rd_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        imm_d        = imm_q;
        imm_type_d   = imm_type_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus_io.flush) begin
            ex_valid_d = 1'b0;
        end else if (slot_free && bus_io.id_valid && !load_use) begin
            ex_valid_d  = 1'b1;
            rs1_addr_d  = bus_io.id_rs1_addr;
            rs2_addr_d  = bus_io.id_rs2_addr;
            rd_d        = bus_io.id_rd_addr;
            rs1_data_d  = bus_io.id_rs1_data;
            rs2_data_d  = bus_io.id_rs2_data;
            funct3_d    = bus_io.id_funct3;
            funct7_d    = bus_io.id_funct7;
            imm_d       = bus_io.id_imm;
            imm_type_d  = bus_io.id_imm_type;
            reg_write_d = bus_io.id_reg_write;
            mem_read_d  = bus_io.id_mem_read;
        end else if (ex_valid_q && bus_io.ex_ready && load_use) begin
            ex_valid_d = 1'b0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (slot_free) begin
            ex_valid_d = 1'b0;
        end else begin
            // Stalled: capture forwarded values so a retiring producer is not lost.
            rs1_data_d = op1_fwd;
            rs2_data_d = op2_fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            funct3_q     <= '0;
            funct7_q     <= '0;
            imm_q        <= '0;
            imm_type_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_q         <= rd_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
            imm_q        <= imm_d;
            imm_type_q   <= imm_type_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus_io.ex_valid      = ex_valid_q;
    assign bus_io.op1           = op1_fwd;
    assign bus_io.op2           = op2_fwd;
    assign bus_io.funct3        = funct3_q;
    assign bus_io.funct7        = funct7_q;
    assign bus_io.IMM_Type_flag = imm_type_q;
    assign bus_io.immediate     = imm_q;
    assign bus_io.ex_rd         = rd_q;
    assign bus_io.ex_reg_write  = reg_write_q;
    assign bus_io.ex_mem_read   = mem_read_q;
    assign bus_io.bubble_cnt    = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the held instruction slot.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .IMM_W(12), .CNT_W(16)) bus ();

    id_ex_stage #(.XLEN(32), .IMM_W(12), .CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the one instruction currently occupying the slot.
    typedef struct {
        bit          valid;
        bit [4:0]    rs1, rs2, rd;
        bit [31:0]   d1, d2;
        bit [2:0]    f3;
        bit [6:0]    f7;
        bit [11:0]   imm;
        bit          it, rw, mr;
    } slot_t;
    slot_t   m;
    int      m_bubbles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit [31:0] operand(input bit [4:0] rs, input bit [31:0] stored);
        if (rs == 0) return stored;
        if (bus.exmem_reg_write && bus.exmem_rd == rs) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == rs) return bus.memwb_result;
        return stored;
    endfunction

    function automatic bit hazard();
        if (!(m.valid && m.mr && m.rd != 0 && bus.id_valid)) return 1'b0;
        return (m.rd == bus.id_rs1_addr) || (!bus.id_imm_type && m.rd == bus.id_rs2_addr);
    endfunction

    task automatic clear_inputs();
        rst = 1'b0;
        bus.flush = 0; bus.id_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
        bus.id_rd_addr = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_funct3 = 0;
        bus.id_funct7 = 0; bus.id_imm = 0; bus.id_imm_type = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.exmem_reg_write = 0; bus.exmem_rd = 0;
        bus.exmem_result = 0; bus.memwb_reg_write = 0; bus.memwb_rd = 0;
        bus.memwb_result = 0; bus.ex_ready = 1;
    endtask

    task automatic offer(input bit [4:0] rs1, input bit [31:0] d1, input bit [4:0] rs2,
                         input bit [31:0] d2, input bit [4:0] rd, input bit it,
                         input bit mr, input bit [11:0] imm);
        bus.id_valid = 1; bus.id_rs1_addr = rs1; bus.id_rs1_data = d1;
        bus.id_rs2_addr = rs2; bus.id_rs2_data = d2; bus.id_rd_addr = rd;
        bus.id_imm_type = it; bus.id_mem_read = mr; bus.id_reg_write = 1;
        bus.id_imm = imm; bus.id_funct3 = 3'b000; bus.id_funct7 = 7'h00;
    endtask

    // Check the present cycle against the model, then advance one clock.
    task automatic step();
        bit stall_free, hz;
        #1;
        hz = hazard();
        stall_free = !m.valid || bus.ex_ready;
        if (!rst) begin
            check("ex_valid", bus.ex_valid, m.valid);
            check("id_ready", bus.id_ready, !bus.flush && !hz && stall_free);
            check("bubble_cnt", bus.bubble_cnt, m_bubbles);
            if (m.valid) begin
                check("op1", bus.op1, operand(m.rs1, m.d1));
                check("op2", bus.op2, operand(m.rs2, m.d2));
                check("funct3", bus.funct3, m.f3);
                check("funct7", bus.funct7, m.f7);
                check("imm", bus.immediate, m.imm);
                check("imm_type", bus.IMM_Type_flag, m.it);
                check("ex_rd", bus.ex_rd, m.rd);
                check("ex_rw", bus.ex_reg_write, m.rw);
                check("ex_mr", bus.ex_mem_read, m.mr);
            end
        end
        if (rst) begin
            m = '{default: 0};
            m_bubbles = 0;
        end else if (bus.flush) begin
            m.valid = 0;
        end else if (stall_free && bus.id_valid && !hz) begin
            m = '{valid: 1, rs1: bus.id_rs1_addr, rs2: bus.id_rs2_addr, rd: bus.id_rd_addr,
                  d1: bus.id_rs1_data, d2: bus.id_rs2_data, f3: bus.id_funct3,
                  f7: bus.id_funct7, imm: bus.id_imm, it: bus.id_imm_type,
                  rw: bus.id_reg_write, mr: bus.id_mem_read};
        end else if (m.valid && bus.ex_ready && hz) begin
            m.valid = 0;
            if (m_bubbles < 65535) m_bubbles++;
        end else if (stall_free) begin
            m.valid = 0;
        end else begin
            m.d1 = operand(m.rs1, m.d1);
            m.d2 = operand(m.rs2, m.d2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saved_bub;
        m = '{default: 0};
        m_bubbles = 0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        #1;
        check("rst_op1", bus.op1, 0);
        check("rst_op2", bus.op2, 0);
        check("rst_id_ready", bus.id_ready, 1);
        step();

        // ADDI x1, x5, -3
        offer(5'd5, 32'h10, 5'd0, 32'h0, 5'd1, 1'b1, 1'b0, 12'hFFD);
        step();
        bus.id_valid = 0;
        #1;
        check("addi_valid", bus.ex_valid, 1);
        check("addi_op1", bus.op1, 32'h10);
        check("addi_imm", bus.immediate, 12'hFFD);
        check("addi_it", bus.IMM_Type_flag, 1);
        check("addi_f3", bus.funct3, 0);
        step();

        // ADD with rs1=x3; both forwarding stages target x3
        offer(5'd3, 32'h1, 5'd2, 32'h0, 5'd9, 1'b0, 1'b0, 12'h0);
        step();
        offer(5'd0, 32'h77, 5'd2, 32'h0, 5'd9, 1'b0, 1'b0, 12'h0);
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB;
        #1;
        check("fwd_exmem_prio", bus.op1, 32'hAA);
        step();
        bus.id_valid = 0;
        bus.exmem_rd = 5'd0;
        bus.memwb_reg_write = 0;
        #1;
        check("fwd_x0", bus.op1, 32'h77);
        step();
        bus.exmem_reg_write = 0;

        // Load-use: LW x7 then ADD x8, x7, x2
        offer(5'd1, 32'h100, 5'd0, 32'h0, 5'd7, 1'b1, 1'b1, 12'h4);
        step();
        offer(5'd7, 32'h0, 5'd2, 32'h2, 5'd8, 1'b0, 1'b0, 12'h0);
        #1;
        check("lu_id_ready", bus.id_ready, 0);
        step();
        check("lu_bubble", bus.ex_valid, 0);
        check("lu_cnt", bus.bubble_cnt, 1);
        check("lu_ready_after", bus.id_ready, 1);
        step();
        check("lu_accept", bus.ex_valid, 1);
        check("lu_rd", bus.ex_rd, 8);

        // Stall with a MEM/WB forward present only on the first stall cycle
        offer(5'd0, 32'h0, 5'd4, 32'h9, 5'd10, 1'b0, 1'b0, 12'h0);
        step();
        bus.ex_ready = 0;
        offer(5'd11, 32'h0, 5'd12, 32'h0, 5'd13, 1'b0, 1'b0, 12'h0);
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd4; bus.memwb_result = 32'h55;
        #1;
        check("stall1_op2", bus.op2, 32'h55);
        step();
        bus.memwb_reg_write = 0;
        for (int i = 2; i <= 3; i++) begin
            #1;
            check("stall_op2", bus.op2, 32'h55);
            check("stall_id_ready", bus.id_ready, 0);
            step();
        end

        // Flush while full and decode offering
        saved_bub = m_bubbles;
        bus.flush = 1;
        bus.ex_ready = 1;
        #1;
        check("flush_id_ready", bus.id_ready, 0);
        step();
        bus.flush = 0;
        bus.id_valid = 0;
        #1;
        check("flush_valid", bus.ex_valid, 0);
        check("flush_cnt", bus.bubble_cnt, saved_bub);
        step();

        // Random traffic on a small register window to provoke hazards and forwards
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_rs1_addr = 5'($urandom_range(0, 7));
            bus.id_rs2_addr = 5'($urandom_range(0, 7));
            bus.id_rd_addr = 5'($urandom_range(0, 7));
            bus.id_rs1_data = $urandom;
            bus.id_rs2_data = $urandom;
            bus.id_funct3 = 3'($urandom);
            bus.id_funct7 = 7'($urandom);
            bus.id_imm = 12'($urandom);
            bus.id_imm_type = 1'($urandom);
            bus.id_reg_write = 1'($urandom);
            bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.exmem_reg_write = 1'($urandom);
            bus.exmem_rd = 5'($urandom_range(0, 7));
            bus.exmem_result = $urandom;
            bus.memwb_reg_write = 1'($urandom);
            bus.memwb_rd = 5'($urandom_range(0, 7));
            bus.memwb_result = $urandom;
            bus.ex_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
